// File: rtl/simon_pkg.sv
// Shared constants and helpers for the Simon sequence datapath.
package simon_pkg;

  localparam logic LVL_EASY = 1'b0;
  localparam logic LVL_HARD = 1'b1;

  // Callers zero-extend their button vector to 32 bits.
  function automatic logic is_onehot(input logic [31:0] v);
    return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
  endfunction

endpackage

// File: rtl/simon_seq_engine_if.sv
// Control strobes from the Simon controller and status returned by the sequence engine.
interface simon_seq_engine_if #(
  parameter int unsigned N_BTN = 4,
  parameter int unsigned DEPTH = 64
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic             level;
  logic             new_game;
  logic [N_BTN-1:0] pattern;
  logic             seq_inc;
  logic             pb_inc;
  logic             led;
  logic             wr;
  logic             lvl;
  logic             legal;
  logic             correct;
  logic             more;
  logic             full;
  logic [AW:0]      best;
  logic [N_BTN-1:0] pattern_leds;
  logic             timeout;

  modport master (
    output level, new_game, pattern, seq_inc, pb_inc, led, wr,
    input  lvl, legal, correct, more, full, best, pattern_leds, timeout
  );

  modport slave (
    input  level, new_game, pattern, seq_inc, pb_inc, led, wr,
    output lvl, legal, correct, more, full, best, pattern_leds, timeout
  );
endinterface

// File: rtl/simon_seq_mem.sv
// Sequence storage: synchronous write port, combinational read port, contents not reset.
module simon_seq_mem #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned N_BTN = 4
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [N_BTN-1:0]         wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [N_BTN-1:0]         rdata_o
);

  logic [N_BTN-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/simon_seq_engine.sv
// Simon sequence datapath: stores, replays and checks the button sequence.
// Optional input-idle timeout is built when SIMON_TIMEOUT_EN is defined.
module simon_seq_engine
  import simon_pkg::*;
#(
  parameter int unsigned N_BTN         = 4,
  parameter int unsigned DEPTH         = 64,
  parameter int unsigned TIMEOUT_TICKS = 50_000_000
) (
  input logic                clk,
  input logic                rst_n,
  simon_seq_engine_if.slave  bus
);

  localparam int unsigned AW     = $clog2(DEPTH);
  localparam logic [AW:0] DepthW = (AW + 1)'(DEPTH);

  logic [AW:0]      seq_q, seq_d, best_q, best_d, seq_m1, pb_ext;
  logic [AW-1:0]    pb_q, pb_d;
  logic             lvl_q, lvl_d, led_q;
  logic             full, mem_we;
  logic [N_BTN-1:0] rd_data;

  assign full   = (seq_q == DepthW);
  assign seq_m1 = seq_q - (AW + 1)'(1);
  assign pb_ext = {1'b0, pb_q};
  assign mem_we = bus.wr && !full && !bus.new_game;

  simon_seq_mem #(
    .DEPTH(DEPTH),
    .N_BTN(N_BTN)
  ) u_mem (
    .clk_i  (clk),
    .we_i   (mem_we),
    .waddr_i(seq_q[AW-1:0]),
    .wdata_i(bus.pattern),
    .raddr_i(pb_q),
    .rdata_o(rd_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seq_q  <= '0;
      pb_q   <= '0;
      lvl_q  <= LVL_EASY;
      best_q <= '0;
      led_q  <= 1'b0;
    end else begin
      seq_q  <= seq_d;
      pb_q   <= pb_d;
      lvl_q  <= lvl_d;
      best_q <= best_d;
      led_q  <= bus.led;
    end
  end

  always_comb begin
    seq_d  = seq_q;
    pb_d   = pb_q;
    lvl_d  = lvl_q;
    best_d = best_q;
    if (bus.new_game) begin
      seq_d = '0;
      pb_d  = '0;
      lvl_d = bus.level;
      if (seq_q > best_q) best_d = seq_q;
    end else begin
      if (bus.seq_inc && !full) seq_d = seq_q + (AW + 1)'(1);
      // Entering playback restarts the pointer on the very edge led is first seen high.
      if (bus.led && !led_q) begin
        pb_d = '0;
      end else if (bus.pb_inc) begin
        if (seq_q == '0 || pb_ext == seq_m1) pb_d = '0;
        else                                 pb_d = pb_q + AW'(1);
      end
    end
  end

  assign bus.lvl          = lvl_q;
  assign bus.best         = best_q;
  assign bus.full         = full;
  assign bus.legal        = (lvl_q == LVL_HARD) ? (|bus.pattern) : is_onehot(32'(bus.pattern));
  assign bus.correct      = (bus.pattern == rd_data) && (pb_ext < seq_q);
  assign bus.more         = (seq_q != '0) && (pb_ext < seq_m1);
  assign bus.pattern_leds = bus.led ? rd_data : bus.pattern;

`ifdef SIMON_TIMEOUT_EN
  localparam int unsigned TW = (TIMEOUT_TICKS > 2) ? $clog2(TIMEOUT_TICKS) : 1;

  logic [TW-1:0] idle_q, idle_d;
  logic          timeout_q, timeout_d;
  logic          idle_clr;

  assign idle_clr = bus.new_game || bus.led || (|bus.pattern);

  always_comb begin
    idle_d    = idle_q;
    timeout_d = timeout_q;
    if (idle_clr) begin
      idle_d    = '0;
      timeout_d = 1'b0;
    end else if (seq_q != '0) begin
      // Counter parks at the terminal count; timeout stays sticky until a clear event.
      if (idle_q == TW'(TIMEOUT_TICKS - 1)) timeout_d = 1'b1;
      else                                  idle_d    = idle_q + TW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      idle_q    <= idle_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.timeout = timeout_q;
`else
  assign bus.timeout = 1'b0;
`endif

endmodule

// File: tb/tb_simon_seq_engine.sv
// Randomised self-checking bench for simon_seq_engine against a game-level reference model.
module tb_simon_seq_engine;

  localparam int unsigned NB = 4;
  localparam int unsigned DP = 8;
  localparam int unsigned TT = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  simon_seq_engine_if #(.N_BTN(NB), .DEPTH(DP)) bus ();

  simon_seq_engine #(
    .N_BTN        (NB),
    .DEPTH        (DP),
    .TIMEOUT_TICKS(TT)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: the game as stored entries plus latched level and best length.
  logic [NB-1:0] m_seq[$];
  int            m_best = 0;
  logic          m_lvl  = 1'b0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.level    = 1'b0;
    bus.new_game = 1'b0;
    bus.pattern  = '0;
    bus.seq_inc  = 1'b0;
    bus.pb_inc   = 1'b0;
    bus.led      = 1'b0;
    bus.wr       = 1'b0;
  endtask

  task automatic do_new_game(input logic lv);
    bus.level    = lv;
    bus.new_game = 1'b1;
    tick();
    bus.new_game = 1'b0;
    if (m_seq.size() > m_best) m_best = m_seq.size();
    m_seq.delete();
    m_lvl = lv;
  endtask

  task automatic push(input logic [NB-1:0] p);
    bus.pattern = p;
    bus.wr      = 1'b1;
    bus.seq_inc = 1'b1;
    tick();
    bus.wr      = 1'b0;
    bus.seq_inc = 1'b0;
    bus.pattern = '0;
    if (m_seq.size() < DP) m_seq.push_back(p);
  endtask

  task automatic model_reset();
    m_seq.delete();
    m_best = 0;
    m_lvl  = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    #2;
    checks++;
    if ({bus.lvl, bus.more, bus.full, bus.correct, bus.timeout} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags got %b want 00000",
               {bus.lvl, bus.more, bus.full, bus.correct, bus.timeout});
    end
    checks++;
    if (bus.best !== '0) begin
      errors++;
      $display("FAIL reset_best got %0d want 0", bus.best);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    model_reset();
    // Build up state, then drop reset between clock edges.
    do_new_game(1'b1);
    for (int i = 0; i < 5; i++) push(NB'($urandom_range(1, 15)));
    do_new_game(1'b1);
    for (int i = 0; i < 5; i++) push(NB'($urandom_range(1, 15)));
    checks++;
    if (bus.more !== 1'b1 || bus.best !== 4'(m_best) || bus.lvl !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset got more=%b best=%0d lvl=%b want 1 %0d 1",
               bus.more, bus.best, bus.lvl, m_best);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.lvl, bus.more, bus.full, bus.timeout} !== 4'b0 || bus.best !== '0) begin
      errors++;
      $display("FAIL async_reset got lvl=%b more=%b full=%b to=%b best=%0d want all 0",
               bus.lvl, bus.more, bus.full, bus.timeout, bus.best);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    model_reset();
  endtask

  task automatic test_legal();
    logic [NB-1:0] fixed[3];
    logic [NB-1:0] p;
    logic          exp;
    fixed[0] = 4'b0100;
    fixed[1] = 4'b0110;
    fixed[2] = 4'b0000;
    for (int lv = 0; lv < 2; lv++) begin
      do_new_game(lv[0]);
      checks++;
      if (bus.lvl !== m_lvl) begin
        errors++;
        $display("FAIL lvl_latch got %b want %b", bus.lvl, m_lvl);
      end
      for (int k = 0; k < 23; k++) begin
        p = (k < 3) ? fixed[k] : NB'($urandom_range(0, 15));
        bus.pattern = p;
        #1;
        exp = m_lvl ? (p != 0) : ($countones(p) == 1);
        checks++;
        if (bus.legal !== exp) begin
          errors++;
          $display("FAIL legal lvl=%b pat=%b got %b want %b", m_lvl, p, bus.legal, exp);
        end
      end
      bus.pattern = '0;
    end
  endtask

  task automatic test_playback(input int len, input bit rnd);
    logic [NB-1:0] tbl[3];
    int            ptr;
    int            pre;
    tbl[0] = 4'b0001;
    tbl[1] = 4'b0010;
    tbl[2] = 4'b1000;
    do_new_game(1'b0);
    for (int i = 0; i < len; i++) push(rnd ? NB'($urandom_range(1, 15)) : tbl[i % 3]);
    // Wander the pointer first so the playback-entry restart is observable.
    ptr = 0;
    pre = rnd ? $urandom_range(1, len) : 0;
    for (int i = 0; i < pre; i++) begin
      bus.pb_inc = 1'b1;
      tick();
      ptr = (ptr + 1) % len;
    end
    bus.led    = 1'b1;
    bus.pb_inc = 1'b1;
    tick();
    bus.pb_inc = 1'b0;
    ptr = 0;
    for (int k = 0; k <= len + 1; k++) begin
      if (k > 0) begin
        bus.pb_inc = 1'b1;
        tick();
        bus.pb_inc = 1'b0;
        ptr = (ptr + 1) % len;
      end
      checks++;
      if (bus.pattern_leds !== m_seq[ptr] || bus.more !== (ptr < len - 1)) begin
        errors++;
        $display("FAIL playback idx=%0d got leds=%b more=%b want %b %b",
                 ptr, bus.pattern_leds, bus.more, m_seq[ptr], (ptr < len - 1));
      end
      bus.pattern = m_seq[ptr];
      #1;
      checks++;
      if (bus.correct !== 1'b1) begin
        errors++;
        $display("FAIL correct_hit idx=%0d got %b want 1", ptr, bus.correct);
      end
      bus.pattern = ~m_seq[ptr];
      #1;
      checks++;
      if (bus.correct !== 1'b0) begin
        errors++;
        $display("FAIL correct_miss idx=%0d got %b want 0", ptr, bus.correct);
      end
      bus.pattern = '0;
    end
    bus.led = 1'b0;
    tick();
  endtask

  task automatic test_full();
    do_new_game(1'b0);
    for (int i = 0; i < DP + 1; i++) begin
      checks++;
      if (bus.full !== (m_seq.size() == DP)) begin
        errors++;
        $display("FAIL full_pre%0d got %b want %b", i, bus.full, (m_seq.size() == DP));
      end
      push(NB'($urandom_range(1, 15)));
    end
    checks++;
    if (bus.full !== 1'b1) begin
      errors++;
      $display("FAIL full_set got %b want 1", bus.full);
    end
    bus.led = 1'b1;
    tick();
    for (int i = 0; i <= DP; i++) begin
      if (i > 0) begin
        bus.pb_inc = 1'b1;
        tick();
        bus.pb_inc = 1'b0;
      end
      checks++;
      if (bus.pattern_leds !== m_seq[i % DP] || bus.more !== ((i % DP) < DP - 1)) begin
        errors++;
        $display("FAIL full_entry%0d got leds=%b more=%b want %b %b", i % DP,
                 bus.pattern_leds, bus.more, m_seq[i % DP], ((i % DP) < DP - 1));
      end
    end
    bus.led = 1'b0;
    tick();
  endtask

  task automatic test_best();
    int len;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    model_reset();
    do_new_game(1'b0);
    for (int i = 0; i < 3; i++) push(NB'($urandom_range(1, 15)));
    do_new_game(1'b0);
    for (int i = 0; i < 2; i++) push(NB'($urandom_range(1, 15)));
    bus.level = 1'b1;
    tick();
    tick();
    checks++;
    if (bus.lvl !== 1'b0 || bus.best !== 4'(m_best)) begin
      errors++;
      $display("FAIL level_mid_game got lvl=%b best=%0d want 0 %0d", bus.lvl, bus.best, m_best);
    end
    do_new_game(1'b1);
    checks++;
    if (bus.best !== 4'd3 || bus.lvl !== 1'b1) begin
      errors++;
      $display("FAIL best_3_2 got best=%0d lvl=%b want 3 1", bus.best, bus.lvl);
    end
    for (int g = 0; g < 4; g++) begin
      len = $urandom_range(0, DP);
      for (int i = 0; i < len; i++) push(NB'($urandom_range(1, 15)));
      do_new_game(1'($urandom));
      checks++;
      if (bus.best !== 4'(m_best) || bus.lvl !== m_lvl) begin
        errors++;
        $display("FAIL best_rand len=%0d got best=%0d lvl=%b want %0d %b",
                 len, bus.best, bus.lvl, m_best, m_lvl);
      end
    end
  endtask

  task automatic test_timeout();
    do_new_game(1'b0);
    push(4'b0010);
`ifdef SIMON_TIMEOUT_EN
    for (int k = 1; k <= TT + 3; k++) begin
      tick();
      checks++;
      if (bus.timeout !== (k >= TT)) begin
        errors++;
        $display("FAIL timeout_cycle%0d got %b want %b", k, bus.timeout, (k >= TT));
      end
    end
    bus.pattern = 4'b0001;
    tick();
    bus.pattern = '0;
    checks++;
    if (bus.timeout !== 1'b0) begin
      errors++;
      $display("FAIL timeout_clear got %b want 0", bus.timeout);
    end
`else
    for (int k = 0; k < TT + 3; k++) tick();
    checks++;
    if (bus.timeout !== 1'b0) begin
      errors++;
      $display("FAIL timeout_off got %b want 0", bus.timeout);
    end
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_legal();
    test_playback(3, 1'b0);
    for (int r = 0; r < 4; r++) test_playback($urandom_range(1, DP), 1'b1);
    test_full();
    test_best();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
